// File: rtl/sar_adc_ctrl_8bit.sv
// SAR ADC controller: sample/hold, binary search against an external DAC
// and comparator, and a one-cycle valid strobe with the held result.
module sar_adc_ctrl_8bit #(
  parameter int WIDTH         = 8,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic             cmp,
  output logic             sample,
  output logic             dac_ena,
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  localparam int BW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CMAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ?
                        SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0]    SMP_LAST = CW'(SAMPLE_CYCLES - 1);
  localparam logic [CW-1:0]    STL_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [BW-1:0]    TOP      = BW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MSB      = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_SAMPLE,
    S_CONV,
    S_DONE
  } state_t;

  state_t           r_state, w_state;
  logic [CW-1:0]    r_cnt, w_cnt;
  logic [BW-1:0]    r_bit, w_bit;
  logic [BW-1:0]    w_bit_dn;
  logic [WIDTH-1:0] r_code, w_code;
  logic [WIDTH-1:0] r_data, w_data;
  logic             r_sample, w_sample;
  logic             r_ena, w_ena;
  logic             r_busy, w_busy;
  logic             r_valid, w_valid;

  assign w_bit_dn = r_bit - BW'(1);

  assign sample   = r_sample;
  assign dac_ena  = r_ena;
  assign dac_code = r_code;
  assign busy     = r_busy;
  assign data     = r_data;
  assign valid    = r_valid;

  // Register state, counters and all outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_code   <= '0;
      r_data   <= '0;
      r_sample <= 1'b0;
      r_ena    <= 1'b0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_bit    <= w_bit;
      r_code   <= w_code;
      r_data   <= w_data;
      r_sample <= w_sample;
      r_ena    <= w_ena;
      r_busy   <= w_busy;
      r_valid  <= w_valid;
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_bit    = r_bit;
    w_code   = r_code;
    w_data   = r_data;
    w_sample = 1'b0;
    w_ena    = 1'b0;
    w_busy   = 1'b0;
    w_valid  = 1'b0;
    if (!en) begin
      w_state = S_IDLE;
      w_cnt   = '0;
      w_bit   = '0;
      w_code  = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_cnt  = '0;
          w_bit  = '0;
          w_code = '0;
          if (start) begin
            w_state  = S_SAMPLE;
            w_sample = 1'b1;
            w_ena    = 1'b1;
            w_busy   = 1'b1;
          end
        end
        S_SAMPLE: begin
          w_ena  = 1'b1;
          w_busy = 1'b1;
          if (r_cnt == SMP_LAST) begin
            w_state = S_CONV;
            w_cnt   = '0;
            w_bit   = TOP;
            w_code  = MSB;
          end else begin
            w_sample = 1'b1;
            w_cnt    = r_cnt + CW'(1);
          end
        end
        S_CONV: begin
          w_ena  = 1'b1;
          w_busy = 1'b1;
          if (r_cnt == STL_LAST) begin
            w_cnt         = '0;
            w_code[r_bit] = cmp;
            if (r_bit != '0) begin
              w_code[w_bit_dn] = 1'b1;
              w_bit            = w_bit_dn;
            end else begin
              w_state = S_DONE;
              w_data  = w_code;
              w_valid = 1'b1;
              w_busy  = 1'b0;
            end
          end else begin
            w_cnt = r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          w_cnt  = '0;
          w_bit  = '0;
          w_code = '0;
          if (start) begin
            w_state  = S_SAMPLE;
            w_sample = 1'b1;
            w_ena    = 1'b1;
            w_busy   = 1'b1;
          end else begin
            w_state = S_IDLE;
          end
        end
        default: begin
          w_state = S_IDLE;
          w_code  = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sar_adc_ctrl_8bit.sv
// Directed bench for sar_adc_ctrl_8bit with a linear DAC/comparator model
// (0..3.3V over codes 0..255, input given in millivolts).
module tb_sar_adc_ctrl_8bit;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       start;
  logic       cmp;
  logic       sample;
  logic       dac_ena;
  logic [7:0] dac_code;
  logic       busy;
  logic [7:0] data;
  logic       valid;

  int vin_mv;
  int total;
  int bad;

  sar_adc_ctrl_8bit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .start    (start),
    .cmp      (cmp),
    .sample   (sample),
    .dac_ena  (dac_ena),
    .dac_code (dac_code),
    .busy     (busy),
    .data     (data),
    .valid    (valid)
  );

  assign cmp = (vin_mv * 255 >= int'(dac_code) * 3300);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one conversion. n counts edges after the capture edge E0.
  // start is pulsed again at n==p1 / n==p2 (use -1 for none).
  task automatic do_conv(input int vin, input int p1, input int p2,
                         output int lat, output int shi, output int bhi);
    int n;
    vin_mv = vin;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    n = 0;
    shi = 0;
    bhi = 0;
    lat = -1;
    while (n < 100 && lat < 0) begin
      @(negedge clk);
      start = (n == p1) || (n == p2);
      if (sample) shi++;
      if (busy) bhi++;
      if (valid) lat = n;
      else begin
        @(posedge clk);
        n++;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    total++;
    if ({sample, dac_ena, dac_code, busy, data, valid} !== 20'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0",
               {sample, dac_ena, dac_code, busy, data, valid});
    end
  endtask

  task automatic test_mid_scale;
    int lat, shi, bhi;
    do_conv(1650, -1, -1, lat, shi, bhi);
    total++;
    if (lat !== 20) begin
      bad++;
      $display("FAIL mid_latency got=%0d want=20", lat);
    end
    total++;
    if (data !== 8'h7F) begin
      bad++;
      $display("FAIL mid_data got=%h want=7f", data);
    end
    total++;
    if (shi !== 4 || bhi !== 20) begin
      bad++;
      $display("FAIL mid_sample_busy got=%0d/%0d want=4/20", shi, bhi);
    end
    total++;
    if (dac_code !== 8'h7F || dac_ena !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_done_outputs code=%h ena=%b busy=%b want=7f/1/0",
               dac_code, dac_ena, busy);
    end
    @(negedge clk);
    total++;
    if ({valid, dac_ena, busy, dac_code} !== 11'd0) begin
      bad++;
      $display("FAIL mid_idle_after got=%h want=0",
               {valid, dac_ena, busy, dac_code});
    end
  endtask

  task automatic test_rails;
    int lat, shi, bhi;
    do_conv(3300, -1, -1, lat, shi, bhi);
    total++;
    if (data !== 8'hFF || lat !== 20 || shi !== 4) begin
      bad++;
      $display("FAIL rail_high got=%h/%0d/%0d want=ff/20/4", data, lat, shi);
    end
    @(negedge clk);
    total++;
    if (dac_ena !== 1'b0 || valid !== 1'b0) begin
      bad++;
      $display("FAIL rail_high_idle ena=%b valid=%b want=0/0", dac_ena, valid);
    end
    do_conv(0, -1, -1, lat, shi, bhi);
    total++;
    if (data !== 8'h00 || lat !== 20 || shi !== 4) begin
      bad++;
      $display("FAIL rail_low got=%h/%0d/%0d want=00/20/4", data, lat, shi);
    end
    @(negedge clk);
    total++;
    if (dac_ena !== 1'b0 || valid !== 1'b0) begin
      bad++;
      $display("FAIL rail_low_idle ena=%b valid=%b want=0/0", dac_ena, valid);
    end
  endtask

  task automatic test_en_drop;
    int nv;
    vin_mv = 1650;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    total++;
    if (dac_code !== 8'h60 || busy !== 1'b1) begin
      bad++;
      $display("FAIL en_bit5_code got=%h/%b want=60/1", dac_code, busy);
    end
    en = 1'b0;
    @(negedge clk);
    total++;
    if ({sample, dac_ena, busy, valid, dac_code} !== 12'd0) begin
      bad++;
      $display("FAIL en_drop_outputs got=%h want=0",
               {sample, dac_ena, busy, valid, dac_code});
    end
    total++;
    if (data !== 8'h7F) begin
      bad++;
      $display("FAIL en_drop_data got=%h want=7f", data);
    end
    en = 1'b1;
    nv = 0;
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);
      if (valid || busy) nv++;
    end
    total++;
    if (nv !== 0) begin
      bad++;
      $display("FAIL en_drop_no_valid got=%0d want=0", nv);
    end
  endtask

  task automatic test_back_to_back;
    int vpos[$];
    int berr, derr;
    vin_mv = 1000;
    berr = 0;
    derr = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int n = 0; n <= 62; n++) begin
      @(negedge clk);
      if (valid) begin
        vpos.push_back(n);
        if (data !== 8'h4D) derr++;
      end
      if (busy === valid) berr++;
      if (n == 62) start = 1'b0;
    end
    total++;
    if (vpos.size() !== 3) begin
      bad++;
      $display("FAIL b2b_count got=%0d want=3", vpos.size());
    end else begin
      total++;
      if (vpos[0] !== 20 || vpos[1] !== 41 || vpos[2] !== 62) begin
        bad++;
        $display("FAIL b2b_period got=%0d,%0d,%0d want=20,41,62",
                 vpos[0], vpos[1], vpos[2]);
      end
    end
    total++;
    if (derr !== 0) begin
      bad++;
      $display("FAIL b2b_data errs=%0d want=0 last=%h want=4d", derr, data);
    end
    total++;
    if (berr !== 0) begin
      bad++;
      $display("FAIL b2b_busy errs=%0d want=0", berr);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_stop busy=%b valid=%b want=0/0", busy, valid);
    end
  endtask

  task automatic test_reset_mid;
    int lat, shi, bhi;
    vin_mv = 1650;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({sample, dac_ena, dac_code, busy, data, valid} !== 20'd0) begin
      bad++;
      $display("FAIL rst_mid_outputs got=%h want=0",
               {sample, dac_ena, dac_code, busy, data, valid});
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_conv(1000, -1, -1, lat, shi, bhi);
    total++;
    if (data !== 8'h4D || lat !== 20) begin
      bad++;
      $display("FAIL rst_mid_rerun got=%h/%0d want=4d/20", data, lat);
    end
  endtask

  task automatic test_restart_ignored;
    int lat, shi, bhi, nv;
    do_conv(1650, 2, 10, lat, shi, bhi);
    total++;
    if (data !== 8'h7F || lat !== 20 || shi !== 4) begin
      bad++;
      $display("FAIL restart_conv got=%h/%0d/%0d want=7f/20/4",
               data, lat, shi);
    end
    nv = 0;
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);
      if (valid || busy) nv++;
    end
    total++;
    if (nv !== 0) begin
      bad++;
      $display("FAIL restart_extra_valid got=%0d want=0", nv);
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    rst_n  = 1'b0;
    en     = 1'b1;
    start  = 1'b0;
    vin_mv = 0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_mid_scale();
    test_en_drop();
    test_rails();
    test_back_to_back();
    test_reset_mid();
    test_restart_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
